// File: rtl/bist_sched_pkg.sv
// Shared encodings and width helpers for the logic-BIST session scheduler.
package bist_sched_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SELECT   = 4'd1,
    RST_CORE = 4'd2,
    GEN_DATA = 4'd3,
    SHIFT    = 4'd4,
    NORMAL   = 4'd5,
    SIGN     = 4'd6,
    COMPARE  = 4'd7,
    DONE     = 4'd8
  } state_t;

  // Counters get one spare bit so the terminal compare never needs a wrap.
  function automatic int cnt_w(input int x);
    return $clog2(x) + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_lsb_picker.sv
// Combinational lowest-set-bit picker: one-hot, binary index and empty flag.
module bist_lsb_picker
  import bist_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_pending,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_none
);

  always_comb begin
    o_onehot = i_pending & (~i_pending + {{(N-1){1'b0}}, 1'b1});
    o_none   = ~|i_pending;
    o_idx    = '0;
    // Descending scan so the lowest set bit is the last writer.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_pending[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/bist_session_scheduler.sv
// Sequences BIST sessions over cores sharing one PRPG/SRSG/SISA/MISR socket.
// Optional: define BIST_ABORT_EN to add the abort input and aborted flag.
module bist_session_scheduler
  import bist_sched_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int CHAIN_LEN    = 16,
  parameter int NUM_PATTERNS = 50,
  parameter int SIG_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rstIn,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           core_mask,
  input  logic [SIG_WIDTH-1:0]           misr_sig,
  input  logic [NUM_CORES*SIG_WIDTH-1:0] golden_sig,
`ifdef BIST_ABORT_EN
  input  logic                           abort,
  output logic                           aborted,
`endif
  output logic [NUM_CORES-1:0]           core_sel,
  output logic                           NbarT,
  output logic                           rstOut,
  output logic                           PRPG_En,
  output logic                           SRSG_En,
  output logic                           SISA_En,
  output logic                           MISR_En,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_CORES-1:0]           pass_vec,
  output logic [NUM_CORES-1:0]           fail_vec
);

  localparam int SHW = cnt_w(CHAIN_LEN);
  localparam int PTW = cnt_w(NUM_PATTERNS);
  localparam int IW  = idx_w(NUM_CORES);
  localparam logic [SHW-1:0] SH_LAST = SHW'(CHAIN_LEN - 1);
  localparam logic [PTW-1:0] PT_LAST = PTW'(NUM_PATTERNS - 1);

  state_t                 r_state;
  logic [NUM_CORES-1:0]   r_pending;
  logic [NUM_CORES-1:0]   r_core_sel;
  logic [IW-1:0]          r_core_idx;
  logic [SHW-1:0]         r_sh_cnt;
  logic [PTW-1:0]         r_pt_cnt;
  logic [NUM_CORES-1:0]   r_pass_vec;
  logic [NUM_CORES-1:0]   r_fail_vec;

  logic [NUM_CORES-1:0]   w_onehot;
  logic [IW-1:0]          w_idx;
  logic                   w_none;
  logic [SIG_WIDTH-1:0]   w_gold;
  logic                   w_abort;

  bist_lsb_picker #(.N(NUM_CORES), .IW(IW)) u_pick (
    .i_pending (r_pending),
    .o_onehot  (w_onehot),
    .o_idx     (w_idx),
    .o_none    (w_none)
  );

  assign w_gold = golden_sig[r_core_idx*SIG_WIDTH +: SIG_WIDTH];

`ifdef BIST_ABORT_EN
  logic r_aborted;
  assign aborted = r_aborted;
  assign w_abort = abort && (r_state != IDLE) && (r_state != DONE);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_core_sel <= '0;
      r_core_idx <= '0;
      r_sh_cnt   <= '0;
      r_pt_cnt   <= '0;
      r_pass_vec <= '0;
      r_fail_vec <= '0;
`ifdef BIST_ABORT_EN
      r_aborted  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pending  <= core_mask;
            r_pass_vec <= '0;
            r_fail_vec <= '0;
`ifdef BIST_ABORT_EN
            r_aborted  <= 1'b0;
`endif
            r_state    <= SELECT;
          end
        end
        SELECT: begin
          if (w_none) begin
            r_state <= DONE;
          end else begin
            r_core_idx <= w_idx;
            r_pending  <= r_pending & ~w_onehot;
            r_core_sel <= w_onehot;
            r_state    <= RST_CORE;
          end
        end
        RST_CORE: begin
          r_pt_cnt <= '0;
          r_state  <= GEN_DATA;
        end
        GEN_DATA: begin
          r_sh_cnt <= '0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          r_sh_cnt <= r_sh_cnt + 1'b1;
          if (r_sh_cnt >= SH_LAST) r_state <= NORMAL;
        end
        NORMAL: r_state <= SIGN;
        SIGN: begin
          r_pt_cnt <= r_pt_cnt + 1'b1;
          r_state  <= (r_pt_cnt < PT_LAST) ? GEN_DATA : COMPARE;
        end
        COMPARE: begin
          // An abort landing here must not leave a verdict for this core.
          if (!w_abort) begin
            if (misr_sig == w_gold) r_pass_vec[r_core_idx] <= 1'b1;
            else                    r_fail_vec[r_core_idx] <= 1'b1;
          end
          r_state <= SELECT;
        end
        DONE: begin
          r_core_sel <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_abort) begin
        r_state   <= DONE;
`ifdef BIST_ABORT_EN
        r_aborted <= 1'b1;
`endif
      end
    end
  end

  // Socket controls are a pure function of the current state.
  always_comb begin
    NbarT   = 1'b0;
    rstOut  = 1'b0;
    PRPG_En = 1'b0;
    SRSG_En = 1'b0;
    SISA_En = 1'b0;
    MISR_En = 1'b0;
    done    = 1'b0;
    case (r_state)
      RST_CORE: begin rstOut = 1'b1; NbarT = 1'b1; end
      GEN_DATA: PRPG_En = 1'b1;
      SHIFT:    begin NbarT = 1'b1; SRSG_En = 1'b1; SISA_En = 1'b1; end
      SIGN:     MISR_En = 1'b1;
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  assign busy     = (r_state != IDLE);
  assign core_sel = r_core_sel;
  assign pass_vec = r_pass_vec;
  assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Scoreboard bench for bist_session_scheduler (4 cores, 4-bit chains, 3 patterns).
module tb_bist_session_scheduler;

  localparam int NC  = 4;
  localparam int CL  = 4;
  localparam int NP  = 3;
  localparam int SW  = 16;
  localparam int PER_CORE = 1 + 1 + NP * (CL + 3) + 1;
  localparam logic [SW-1:0] SIG = 16'h1234;

  logic              clk = 1'b0;
  logic              rstIn;
  logic              start;
  logic [NC-1:0]     core_mask;
  logic [SW-1:0]     misr_sig;
  logic [NC*SW-1:0]  golden_sig;
  logic [NC-1:0]     core_sel;
  logic              NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En;
  logic              busy, done;
  logic [NC-1:0]     pass_vec, fail_vec;
`ifdef BIST_ABORT_EN
  logic              abort;
  logic              aborted;
`endif

  typedef struct {
    logic [NC-1:0] pass;
    logic [NC-1:0] fail;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [NC-1:0] exp_sel[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bist_session_scheduler #(
    .NUM_CORES(NC), .CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SIG_WIDTH(SW)
  ) dut (
    .clk(clk), .rstIn(rstIn), .start(start), .core_mask(core_mask),
    .misr_sig(misr_sig), .golden_sig(golden_sig),
`ifdef BIST_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .core_sel(core_sel), .NbarT(NbarT), .rstOut(rstOut), .PRPG_En(PRPG_En),
    .SRSG_En(SRSG_En), .SISA_En(SISA_En), .MISR_En(MISR_En),
    .busy(busy), .done(done), .pass_vec(pass_vec), .fail_vec(fail_vec)
  );

  function automatic logic [4*NC+7:0] all_outs();
    return {core_sel, NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En,
            busy, done, pass_vec, fail_vec};
  endfunction

  task automatic set_goldens(input logic [NC-1:0] bad_gold);
    for (int i = 0; i < NC; i++) golden_sig[i*SW +: SW] = bad_gold[i] ? 16'hDEAD : SIG;
  endtask

  task automatic test_reset();
    rstIn = 1'b1; start = 1'b0; core_mask = '0; misr_sig = SIG; set_goldens('0);
`ifdef BIST_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL reset_outs got=%h want=0", all_outs());
    end
    @(negedge clk); rstIn = 1'b0;
  endtask

  // Runs one session; the model predicts results, latency and core order up front.
  task automatic run_session(input logic [NC-1:0] mask, input logic [NC-1:0] bad_gold,
                             input bit disturb, input string name);
    exp_t e, got;
    int n = 0, cyc = 0, run = 0, rst_cnt = 0, prpg_cnt = 0;
    int misr_cnt[NC];
    bit seen = 0, srsg_bad = 0, busy_bad = 0;
    logic [NC-1:0] prev_sel = '0;
    set_goldens(bad_gold);
    e.pass = '0; e.fail = '0;
    for (int i = 0; i < NC; i++) begin
      misr_cnt[i] = 0;
      if (mask[i]) begin
        n++;
        if (bad_gold[i]) e.fail[i] = 1'b1; else e.pass[i] = 1'b1;
        exp_sel.push_back(NC'(1) << i);
      end
    end
    e.lat = n * PER_CORE + 2;
    sb.push_back(e);

    @(negedge clk); core_mask = mask; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!seen && cyc < 500) begin
      @(negedge clk); cyc++;
      if (busy !== 1'b1) busy_bad = 1;
      if (core_sel !== prev_sel && core_sel !== '0) begin
        total++;
        if (exp_sel.size() == 0) begin
          bad++; $display("FAIL %s core_sel got=%b want=none", name, core_sel);
        end else begin
          logic [NC-1:0] es;
          es = exp_sel.pop_front();
          if (core_sel !== es) begin
            bad++; $display("FAIL %s core_sel got=%b want=%b", name, core_sel, es);
          end
        end
      end
      prev_sel = core_sel;
      if (SRSG_En === 1'b1) run++;
      else if (run != 0) begin if (run != CL) srsg_bad = 1; run = 0; end
      if (rstOut === 1'b1) rst_cnt++;
      if (PRPG_En === 1'b1) prpg_cnt++;
      if (MISR_En === 1'b1) for (int i = 0; i < NC; i++) if (core_sel[i]) misr_cnt[i]++;
      if (done === 1'b1) seen = 1;
      if (disturb && cyc == 10) begin start = 1'b1; core_mask = ~mask; end
      if (disturb && cyc == 13) start = 1'b0;
    end

    got = sb.pop_front();
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s done_timeout got=none want=cycle %0d", name, got.lat);
      exp_sel.delete();
      return;
    end
    if (cyc != got.lat) begin
      bad++; $display("FAIL %s done_latency got=%0d want=%0d", name, cyc, got.lat);
    end
    total++;
    if (pass_vec !== got.pass || fail_vec !== got.fail) begin
      bad++; $display("FAIL %s results got=%b/%b want=%b/%b", name, pass_vec, fail_vec, got.pass, got.fail);
    end
    total++;
    if (srsg_bad || busy_bad) begin
      bad++; $display("FAIL %s srsg_busy got=%0d/%0d want=0/0", name, srsg_bad, busy_bad);
    end
    total++;
    if (rst_cnt != n || prpg_cnt != n * NP) begin
      bad++; $display("FAIL %s rst_prpg got=%0d/%0d want=%0d/%0d", name, rst_cnt, prpg_cnt, n, n*NP);
    end
    for (int i = 0; i < NC; i++) begin
      total++;
      if (misr_cnt[i] != (mask[i] ? NP : 0)) begin
        bad++; $display("FAIL %s misr_core%0d got=%0d want=%0d", name, i, misr_cnt[i], mask[i] ? NP : 0);
      end
    end
    total++;
    if (exp_sel.size() != 0) begin
      bad++; $display("FAIL %s cores_unvisited got=%0d want=0", name, exp_sel.size());
      exp_sel.delete();
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || core_sel !== '0 ||
        pass_vec !== got.pass || fail_vec !== got.fail) begin
      bad++; $display("FAIL %s idle_hold got=%b%b%b/%b/%b want=000/%b/%b", name,
                      busy, done, core_sel, pass_vec, fail_vec, got.pass, got.fail);
    end
  endtask

  task automatic test_two_cores();     run_session(4'b0101, 4'b0000, 0, "two_cores");  endtask
  task automatic test_mismatch();      run_session(4'b1111, 4'b0100, 0, "mismatch");   endtask
  task automatic test_empty_mask();    run_session(4'b0000, 4'b0000, 0, "empty_mask"); endtask
  task automatic test_disturb();       run_session(4'b0110, 4'b0010, 1, "disturb");    endtask
  task automatic test_back_to_back();  run_session(4'b1000, 4'b0000, 0, "b2b_a");
                                       run_session(4'b0001, 4'b0001, 0, "b2b_b");      endtask

  task automatic test_reset_mid();
    set_goldens('0);
    @(negedge clk); core_mask = 4'b1111; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    // Core 1 shifts during cycles PER_CORE+4 .. PER_CORE+7.
    repeat (PER_CORE + 5) @(negedge clk);
    total++;
    if (SRSG_En !== 1'b1 || core_sel !== 4'b0010) begin
      bad++; $display("FAIL reset_mid_pre got=%b/%b want=1/0010", SRSG_En, core_sel);
    end
    rstIn = 1'b1; #1;
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL reset_mid_outs got=%h want=0", all_outs());
    end
    @(negedge clk); rstIn = 1'b0;
    run_session(4'b0011, 4'b0000, 0, "after_reset");
  endtask

`ifdef BIST_ABORT_EN
  task automatic test_abort();
    int cyc = 0;
    set_goldens('0);
    @(negedge clk); core_mask = 4'b0011; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    // Second pattern of core 1 starts at cycle PER_CORE+1+1+(CL+3)+1.
    while (cyc < PER_CORE + 2 + (CL + 3) + 2) begin @(negedge clk); cyc++; end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++;
    if (done !== 1'b1 || aborted !== 1'b1) begin
      bad++; $display("FAIL abort_done got=%b/%b want=1/1", done, aborted);
    end
    total++;
    if (pass_vec !== 4'b0001 || fail_vec !== 4'b0000) begin
      bad++; $display("FAIL abort_results got=%b/%b want=0001/0000", pass_vec, fail_vec);
    end
    @(negedge clk);
    run_session(4'b0000, 4'b0000, 0, "after_abort");
    total++;
    if (aborted !== 1'b0) begin
      bad++; $display("FAIL abort_clear got=%b want=0", aborted);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_cores();
    test_mismatch();
    test_empty_mask();
    test_disturb();
    test_reset_mid();
    test_back_to_back();
`ifdef BIST_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_session_scheduler.md
Name: bist_session_scheduler

Overview:
- Sequences logic-BIST sessions over NUM_CORES cores that share one PRPG/SRSG/SISA/MISR test socket.
- For each core enabled in a latched mask, in ascending index order: reset the core, run NUM_PATTERNS shift/capture rounds, then compare the MISR signature against that core's golden value.
- Sits between the top-level test access logic (start/results) and the shared test-socket datapath.

Parameters:
- NUM_CORES, 4, number of cores sharing the socket (≥1)
- CHAIN_LEN, 16, scan shift cycles per pattern (≥1)
- NUM_PATTERNS, 50, patterns applied per core (≥1)
- SIG_WIDTH, 16, MISR signature width

Ports:
- clk  in  1  clock
- rstIn  in  1  reset; asynchronous, active-high
- start  in  1  begin session; sampled only in IDLE
- core_mask  in  NUM_CORES  cores to test; latched on accepted start
- misr_sig  in  SIG_WIDTH  current shared MISR signature
- golden_sig  in  NUM_CORES*SIG_WIDTH  golden signatures; core i at slice [i*SIG_WIDTH +: SIG_WIDTH]
- core_sel  out  NUM_CORES  one-hot socket routing to the active core; 0 when no core is active
- NbarT  out  1  1 = test/shift mode, 0 = normal/capture
- rstOut  out  1  reset to the selected core and the socket registers
- PRPG_En, SRSG_En, SISA_En, MISR_En  out  1 each  socket enables
- busy  out  1  high when state ≠ IDLE
- done  out  1  one-cycle pulse at session end
- pass_vec  out  NUM_CORES  tested and signature matched
- fail_vec  out  NUM_CORES  tested and signature mismatched

Behaviour:
- Reset values: state IDLE; all outputs 0; pending mask, counters and core index 0.
- State outputs are Moore-decoded from state only. core_sel is registered.
- State machine:
  - IDLE: if start, latch pending ← core_mask, clear pass_vec/fail_vec, go to SELECT.
  - SELECT: if pending == 0, go to DONE. Else core_idx ← lowest set bit of pending, clear that bit, load core_sel one-hot, go to RST_CORE.
  - RST_CORE: rstOut=1, NbarT=1; clear pattern counter; go to GEN_DATA.
  - GEN_DATA: PRPG_En=1; clear shift counter; go to SHIFT.
  - SHIFT: NbarT=1, SRSG_En=1, SISA_En=1; shift counter increments. Stay while count < CHAIN_LEN-1, else go to NORMAL. SHIFT therefore lasts exactly CHAIN_LEN cycles.
  - NORMAL: NbarT=0, capture cycle; go to SIGN.
  - SIGN: MISR_En=1; pattern counter increments. If count < NUM_PATTERNS-1, go to GEN_DATA; else go to COMPARE.
  - COMPARE: set pass_vec[core_idx] if misr_sig == golden slice, else set fail_vec[core_idx]; go to SELECT.
  - DONE: done=1, core_sel ← 0; go to IDLE.
- Timing:
  - Per pattern: CHAIN_LEN+3 cycles.
  - Per core: 1 (SELECT) + 1 (RST_CORE) + NUM_PATTERNS*(CHAIN_LEN+3) + 1 (COMPARE).
  - Session end: one extra SELECT cycle plus the DONE cycle.
- Counter widths: $clog2(X)+1 bits; no wrap is reachable.
- Boundary conditions:
  - core_mask = 0: IDLE→SELECT→DONE; done pulses 2 cycles after start; result vectors stay 0.
  - start while busy: ignored. core_mask changes mid-session: ignored.
  - pass_vec/fail_vec are held after DONE until the next accepted start; untested bits stay 0.
  - rstIn mid-session: immediate return to IDLE, all outputs 0, results cleared.
  - Invalid state encoding: go to IDLE.

Optional Feature:
- Macro: BIST_ABORT_EN.
- With the macro:
  - Adds input abort (1 bit).
  - abort high in any state other than IDLE/DONE forces the next state to DONE.
  - The current core gets neither a pass nor a fail bit.
  - Adds output aborted (1 bit): set on abort, cleared on the next accepted start.
- Without the macro: no port is added; the session always runs to completion.

Decomposition:
- Package bist_sched_pkg holds:
  - state encoding constants: IDLE, SELECT, RST_CORE, GEN_DATA, SHIFT, NORMAL, SIGN, COMPARE, DONE
  - counter width helper constants
- Sub-module bist_lsb_picker: combinational; pending mask → one-hot lowest set bit plus binary index plus none flag. Instantiated once.

Test Plan (bench config: NUM_CORES=4, CHAIN_LEN=4, NUM_PATTERNS=3, SIG_WIDTH=16; 24 cycles per core):
- core_mask=4'b0101, goldens match →
  - core_sel=0001, then 0100
  - SRSG_En high 4 consecutive cycles per pattern
  - MISR_En pulses 3 times per core
  - done 50 cycles after start accept
  - pass_vec=0101, fail_vec=0000
- core_mask=4'b1111, golden[2]=16'hDEAD mismatching → pass_vec=1011, fail_vec=0100; done after 98 cycles.
- core_mask=0 → done pulses 2 cycles after start; busy high for exactly 2 cycles; results 0.
- start re-pulsed and core_mask changed mid-session → no effect on sequence or results.
- rstIn asserted during SHIFT of core 1 → same cycle: all outputs 0, busy=0, core_sel=0. A new start then runs normally.
- BIST_ABORT_EN: abort during core 1's second pattern → DONE next cycle; aborted=1; core 1 has no pass/fail bit; core 0 result retained.
